// File: rtl/mux_n_reg_pkg.sv
// Shared constants for the registered N-way selector.
package mux_n_reg_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping at N.
module rr_arbiter
  import mux_n_reg_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_req
);

  logic [SEL_W:0] idx;

  // Walk offsets from the far end so the nearest requester to ptr is written last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(i);
      if (idx >= (SEL_W+1)'(N)) begin
        idx = idx - (SEL_W+1)'(N);
      end
      if (req[idx[SEL_W-1:0]]) begin
        grant   = idx[SEL_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-input registered selector with valid/ready output stage; direct or round-robin select.
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   op,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             load_en;
  logic             sel_ok;
  logic             xfer;
  logic [SEL_W-1:0] g;
  logic [SEL_W-1:0] arb_grant;
  logic             arb_any;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  // Grant selection and handshake; in_data only reaches the register, never an output.
  always_comb begin
    load_en  = !out_valid || out_ready;
    g        = op;
    sel_ok   = ({1'b0, op} < (SEL_W+1)'(N));
    if (mode == MODE_RR) begin
      g      = arb_grant;
      sel_ok = arb_any;
    end
    in_ready = '0;
    if (sel_ok && load_en && !reset) begin
      in_ready = N'(1) << g;
    end
    xfer     = |(in_valid & in_ready);
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (g == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= sel_data;
      out_chan  <= g;
      out_valid <= 1'b1;
      if (mode == MODE_RR) begin
        ptr <= (g == SEL_W'(N - 1)) ? '0 : g + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: N=8 instance checked against a behavioural model, plus N=10 and N=5 instances.
module tb_mux_n_reg;
  import mux_n_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         a_mode;
  logic [2:0]   a_op;
  logic [127:0] a_data;
  logic [7:0]   a_valid, a_ready;
  logic [15:0]  a_out_data;
  logic [2:0]   a_out_chan;
  logic         a_out_valid, a_out_ready;

  logic         b_mode;
  logic [3:0]   b_op;
  logic [159:0] b_data;
  logic [9:0]   b_valid, b_ready;
  logic [15:0]  b_out_data;
  logic [3:0]   b_out_chan;
  logic         b_out_valid, b_out_ready;

  logic         c_mode;
  logic [2:0]   c_op;
  logic [79:0]  c_data;
  logic [4:0]   c_valid, c_ready;
  logic [15:0]  c_out_data;
  logic [2:0]   c_out_chan;
  logic         c_out_valid, c_out_ready;

  mux_n_reg #(.WIDTH(16), .N(8)) dut_a (
    .clk(clk), .reset(reset), .mode(a_mode), .op(a_op), .in_data(a_data),
    .in_valid(a_valid), .in_ready(a_ready), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_n_reg #(.WIDTH(16), .N(10)) dut_b (
    .clk(clk), .reset(reset), .mode(b_mode), .op(b_op), .in_data(b_data),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  mux_n_reg #(.WIDTH(16), .N(5)) dut_c (
    .clk(clk), .reset(reset), .mode(c_mode), .op(c_op), .in_data(c_data),
    .in_valid(c_valid), .in_ready(c_ready), .out_data(c_out_data),
    .out_chan(c_out_chan), .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model of the N=8 instance.
  logic        m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  int          m_chan  = 0;
  int          m_ptr   = 0;
  bit          started = 1'b0;

  function automatic logic [7:0] exp_ready();
    if (reset || (m_valid && !a_out_ready)) return 8'h00;
    if (a_mode == MODE_DIRECT) return 8'h01 << a_op;
    for (int k = 0; k < 8; k++) begin
      int c = (m_ptr + k) % 8;
      if (a_valid[c]) return 8'h01 << c;
    end
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    logic [7:0] r;
    int         c;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = 0;
      started = 1'b1;
    end else begin
      r = exp_ready();
      if ((r & a_valid) != 8'h00) begin
        c = 0;
        for (int k = 0; k < 8; k++) if (r[k]) c = k;
        m_data  = a_data[c*16 +: 16];
        m_chan  = c;
        m_valid = 1'b1;
        if (a_mode == MODE_RR) m_ptr = (c + 1) % 8;
      end else if (a_out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model out_valid", 32'(a_out_valid), 32'(m_valid));
      chk("model out_data",  32'(a_out_data),  32'(m_data));
      chk("model out_chan",  32'(a_out_chan),  m_chan);
      chk("model ptr",       32'(dut_a.ptr),   m_ptr);
      chk("model in_ready",  32'(a_ready),     32'(exp_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [12:0] tbl [12];

  initial begin
    tbl = '{ {1'b1, 3'd0, 8'hFF, 1'b1}, {1'b1, 3'd0, 8'hFF, 1'b0}, {1'b1, 3'd0, 8'hFF, 1'b0},
             {1'b1, 3'd0, 8'h55, 1'b1}, {1'b1, 3'd0, 8'h55, 1'b1}, {1'b1, 3'd0, 8'h00, 1'b1},
             {1'b0, 3'd5, 8'h20, 1'b1}, {1'b0, 3'd5, 8'h20, 1'b0}, {1'b0, 3'd6, 8'h00, 1'b1},
             {1'b1, 3'd0, 8'hA0, 1'b1}, {1'b1, 3'd0, 8'hA0, 1'b1}, {1'b1, 3'd0, 8'h01, 1'b1} };

    reset       = 1'b1;
    a_mode      = MODE_RR;
    a_op        = '0;
    a_valid     = 8'hFF;
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) a_data[i*16 +: 16] = 16'h1000 + 16'(i);
    b_mode = MODE_DIRECT; b_op = '0; b_data = '0; b_valid = '0; b_out_ready = 1'b1;
    c_mode = MODE_DIRECT; c_op = '0; c_valid = '0; c_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) c_data[i*16 +: 16] = 16'h0011 * 16'(i);

    tick(); tick();
    chk("reset out_valid", 32'(a_out_valid), 0);
    chk("reset out_data",  32'(a_out_data), 0);
    chk("reset in_ready",  32'(a_ready), 0);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(a_ready), 32'h01);

    // Round robin with everything valid: 0..7 then back to 0.
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr all-valid out_chan", 32'(a_out_chan), k % 8);
      chk("rr all-valid out_valid", 32'(a_out_valid), 1);
    end

    // Backpressure holds everything.
    a_out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall in_ready", 32'(a_ready), 0);
      chk("stall out_chan", 32'(a_out_chan), 0);
      chk("stall out_data", 32'(a_out_data), 32'h1000);
      chk("stall ptr", 32'(dut_a.ptr), 1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(a_ready), 32'h02);
    tick();
    chk("release out_chan", 32'(a_out_chan), 1);
    chk("release out_data", 32'(a_out_data), 32'h1001);
    chk("release out_valid", 32'(a_out_valid), 1);

    // Sparse requests from ptr=2: 7, 1, 7, 1.
    a_valid = 8'h82;
    tick(); chk("sparse rr 1st", 32'(a_out_chan), 7);
    tick(); chk("sparse rr 2nd", 32'(a_out_chan), 1);
    tick(); chk("sparse rr 3rd", 32'(a_out_chan), 7);
    tick(); chk("sparse rr 4th", 32'(a_out_chan), 1);

    // Direct select leaves ptr alone.
    a_mode = MODE_DIRECT;
    a_op   = 3'd3;
    a_valid = 8'h08;
    a_data[48 +: 16] = 16'hBEEF;
    tick();
    chk("direct out_data", 32'(a_out_data), 32'hBEEF);
    chk("direct out_chan", 32'(a_out_chan), 3);
    chk("direct out_valid", 32'(a_out_valid), 1);
    chk("direct ptr kept", 32'(dut_a.ptr), 2);
    a_valid = 8'h00;
    tick();
    chk("drain out_valid", 32'(a_out_valid), 0);
    chk("drain out_data held", 32'(a_out_data), 32'hBEEF);
    a_valid = 8'h08;
    tick(); tick();
    chk("pop+push out_valid", 32'(a_out_valid), 1);

    // Reset while a word is held under backpressure.
    a_out_ready = 1'b0;
    tick();
    chk("held before reset", 32'(a_out_valid), 1);
    reset = 1'b1;
    tick();
    chk("reset-hold out_valid", 32'(a_out_valid), 0);
    chk("reset-hold ptr", 32'(dut_a.ptr), 0);
    reset = 1'b0;

    for (int r = 0; r < 12; r++) begin
      logic [12:0] row;
      row = tbl[r];
      a_mode      = row[12];
      a_op        = row[11:9];
      a_valid     = row[8:1];
      a_out_ready = row[0];
      tick();
    end

    // N=10: op=9 is a real channel, op 10..15 select nothing.
    b_op = 4'd9;
    b_valid = 10'h200;
    b_data[144 +: 16] = 16'h0909;
    #1;
    chk("n10 op9 in_ready", 32'(b_ready), 32'h200);
    tick();
    chk("n10 op9 out_data", 32'(b_out_data), 32'h0909);
    chk("n10 op9 out_chan", 32'(b_out_chan), 9);
    chk("n10 op9 out_valid", 32'(b_out_valid), 1);
    b_valid = 10'h3FF;
    for (int o = 10; o < 16; o++) begin
      b_op = 4'(o);
      #1;
      chk("n10 op>=N in_ready", 32'(b_ready), 0);
    end
    tick();
    chk("n10 op>=N out_valid", 32'(b_out_valid), 0);

    // N=5 round robin wraps 4 -> 0.
    c_mode = MODE_RR;
    c_valid = 5'h1F;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("n5 rr out_chan", 32'(c_out_chan), k % 5);
      chk("n5 rr out_data", 32'(c_out_data), 32'h11 * (k % 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised N-input, WIDTH-bit registered selector with a valid/ready output stage and two selection modes: direct (external select code) and round-robin arbitration among valid inputs. It is the next-generation datapath selector for the processor: it replaces fixed 8-way, 16-bit combinational muxing where a source must be held until the consumer accepts it, such as writeback-source and shared-bus selection. Output is registered, with one-cycle latency and full throughput.

## Interface
Parameters:
- WIDTH, 16, data width per channel
- N, 8, channel count, 2..32, power of two not required
- SEL_W, $clog2(N), select/channel-index width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- mode  in  1  0 = direct select, 1 = round-robin
- op  in  SEL_W  channel select code, used only in direct mode
- in_data  in  N*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready, one-hot or zero
- out_data  out  WIDTH  registered selected data
- out_chan  out  SEL_W  index of channel that produced out_data
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- load_en = !out_valid || out_ready (combinational).
- Direct mode:
  - g = op. If op >= N, no channel is selected, in_ready = 0, and nothing loads.
  - in_ready[g] = load_en. All other ready bits are 0.
- Round-robin mode:
  - g = the first i with in_valid[i] set, searching from ptr upward modulo N.
  - in_ready[g] = load_en. All other ready bits are 0. If no channel is valid, in_ready = 0.
- Transfer on channel g: in_valid[g] && in_ready[g]. At the clock edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - In RR mode only, ptr <= (g == N-1) ? 0 : g+1.
- If out_ready is set and no transfer occurs: out_valid <= 0. out_data and out_chan hold their values.
- If out_valid && !out_ready: all outputs hold, and in_ready = 0.
- ptr (SEL_W bits, internal) is unchanged by direct-mode transfers and by mode changes.
- Mode or op changes take effect on the next selection only. They never alter a held output.
- Reset mid-operation: a held word is discarded with no drain.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready evaluates to a function of these values, so in_ready=0 in RR mode with no valid inputs.
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 word/cycle when out_ready is held high.
- in_ready depends combinationally on out_ready, mode, op, in_valid and ptr. No combinational path exists from in_data to any output.
- Simultaneous pop and push in one cycle: the register reloads and out_valid stays 1.
- Handshake rule: once in_valid[i] is asserted, in_data[i] must be held until transfer. The block never drops a granted word.

## Structure
- Shared package/include: MODE_DIRECT=1'b0, MODE_RR=1'b1.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: grant index, any_req.
  - Purely combinational, with rotate-and-priority-encode handling non-power-of-two wrap.
- Top level: select logic, output register, ptr register.

## Test plan
- Reset with in_valid=8'hFF and mode=RR → out_valid=0, out_data=0, in_ready=0 while reset=1. In the first cycle after reset, in_ready=8'h01.
- Direct mode, op=3, in_data ch3=16'hBEEF, in_valid=8'h08, out_ready=1 → next cycle out_data=16'hBEEF, out_chan=3, out_valid=1. With op=9 under N=10 overrides, ch9 is selected. With op=10..15, in_ready=0.
- RR mode, all 8 valid, out_ready=1 → out_chan sequence 0,1,…,7,0. With N=5 the sequence wraps 4→0.
- RR mode, in_valid=8'b1000_0010, ptr=2 → grant 7, then 1, then 7.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → out_data, out_chan and ptr are stable, and in_ready=0. On release, the held word pops and the next word loads in the same cycle, with out_valid held at 1.
- Reset asserted while out_valid=1 and out_ready=0 → the next cycle shows out_valid=0 and ptr=0. The held word is not emitted.
